// File: rtl/vga_timing_pkg.sv
// Shared constants and types for the raster timing generator.
// Holds the default 640x480@60 timing, the derived totals, the coordinate
// width and the two-state control enum.
package vga_timing_pkg;

  localparam int unsigned H_ACTIVE_DEF = 640;
  localparam int unsigned H_FP_DEF     = 16;
  localparam int unsigned H_SYNC_DEF   = 96;
  localparam int unsigned H_BP_DEF     = 48;
  localparam int unsigned V_ACTIVE_DEF = 480;
  localparam int unsigned V_FP_DEF     = 10;
  localparam int unsigned V_SYNC_DEF   = 2;
  localparam int unsigned V_BP_DEF     = 33;
  localparam bit          HS_POL_DEF   = 1'b0;
  localparam bit          VS_POL_DEF   = 1'b0;

  localparam int unsigned H_TOTAL_DEF = H_ACTIVE_DEF + H_FP_DEF + H_SYNC_DEF + H_BP_DEF;
  localparam int unsigned V_TOTAL_DEF = V_ACTIVE_DEF + V_FP_DEF + V_SYNC_DEF + V_BP_DEF;

  localparam int unsigned COORD_W = 10;

  typedef enum logic {
    StWaitLock = 1'b0,
    StRun      = 1'b1
  } state_e;

endpackage

// File: rtl/vga_timing_gen_if.sv
// Raster output bundle from the timing generator to its consumers
// (pixel buffer, VGA DAC).
//   master: driven by vga_timing_gen
//   slave : observed by downstream consumers
interface vga_timing_gen_if;
  import vga_timing_pkg::*;

  logic               hsync;
  logic               vsync;
  logic               blank;
  logic [COORD_W-1:0] pix_x;
  logic [COORD_W-1:0] pix_y;
  logic               line_start;
  logic               frame_start;
  logic               pix_req;
  logic               running;

  modport master (
    output hsync, vsync, blank, pix_x, pix_y, line_start, frame_start, pix_req, running
  );

  modport slave (
    input  hsync, vsync, blank, pix_x, pix_y, line_start, frame_start, pix_req, running
  );

endinterface

// File: rtl/vga_lock_qualifier.sv
// PLL lock qualifier.
// Synchronizes the asynchronous pll_locked flag through two flops and counts
// consecutive synchronized-locked cycles while the generator is waiting.
//   clk, rst   : pixel clock, synchronous active-high reset
//   pll_locked : raw PLL lock flag (asynchronous)
//   run        : generator is in RUN; holds the count at zero
//   lk_s       : synchronized lock flag
//   lock_ok    : lock has been stable long enough; enter RUN on this edge
module vga_lock_qualifier #(
  parameter int unsigned LOCK_WAIT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic pll_locked,
  input  logic run,
  output logic lk_s,
  output logic lock_ok
);

  localparam int unsigned CntW = (LOCK_WAIT > 1) ? $clog2(LOCK_WAIT) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(LOCK_WAIT - 1);

  logic            sync_q;
  logic            lk_q;
  logic [CntW-1:0] lock_cnt_q;
  logic [CntW-1:0] lock_cnt_d;

  assign lk_s    = lk_q;
  assign lock_ok = lk_q && (lock_cnt_q == CntLast);

  // Count only uninterrupted locked cycles while waiting; the count restarts
  // after any drop and is parked at zero once running.
  always_comb begin
    lock_cnt_d = lock_cnt_q + CntW'(1);
    if (!lk_q || run || lock_ok) begin
      lock_cnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q     <= 1'b0;
      lk_q       <= 1'b0;
      lock_cnt_q <= '0;
    end else begin
      sync_q     <= pll_locked;
      lk_q       <= sync_q;
      lock_cnt_q <= lock_cnt_d;
    end
  end

endmodule

// File: rtl/vga_timing_gen.sv
// Raster timing generator.
// Waits for a qualified PLL lock, then runs the h/v counters and produces
// registered sync, blank, coordinates, start strobes and a lead-time pixel
// request. Every output is decoded from the next-state counters and
// registered, so all outputs describe the same (h,v) as pix_x/pix_y.
//   clk, rst   : pixel clock, synchronous active-high reset
//   pll_locked : raw PLL lock flag (asynchronous)
//   vga        : raster outputs (master modport)
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int unsigned H_ACTIVE  = H_ACTIVE_DEF,
  parameter int unsigned H_FP      = H_FP_DEF,
  parameter int unsigned H_SYNC    = H_SYNC_DEF,
  parameter int unsigned H_BP      = H_BP_DEF,
  parameter int unsigned V_ACTIVE  = V_ACTIVE_DEF,
  parameter int unsigned V_FP      = V_FP_DEF,
  parameter int unsigned V_SYNC    = V_SYNC_DEF,
  parameter int unsigned V_BP      = V_BP_DEF,
  parameter bit          HS_POL    = HS_POL_DEF,
  parameter bit          VS_POL    = VS_POL_DEF,
  parameter int unsigned LOCK_WAIT = 16,
  parameter int unsigned PIX_LEAD  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pll_locked,
  vga_timing_gen_if.master  vga
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned XW      = COORD_W + 1;

  localparam logic [COORD_W-1:0] HLast   = COORD_W'(H_TOTAL - 1);
  localparam logic [COORD_W-1:0] VLast   = COORD_W'(V_TOTAL - 1);
  localparam logic [COORD_W-1:0] HAct    = COORD_W'(H_ACTIVE);
  localparam logic [COORD_W-1:0] VAct    = COORD_W'(V_ACTIVE);
  localparam logic [COORD_W-1:0] HsFirst = COORD_W'(H_ACTIVE + H_FP);
  localparam logic [COORD_W-1:0] HsLast  = COORD_W'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [COORD_W-1:0] VsFirst = COORD_W'(V_ACTIVE + V_FP);
  localparam logic [COORD_W-1:0] VsLast  = COORD_W'(V_ACTIVE + V_FP + V_SYNC - 1);
  localparam logic [XW-1:0]      LeadX   = XW'(PIX_LEAD);
  localparam logic [XW-1:0]      HActX   = XW'(H_ACTIVE);

  state_e             state_q, state_d;
  logic [COORD_W-1:0] h_q, h_d;
  logic [COORD_W-1:0] v_q, v_d;
  logic               lk_s;
  logic               lock_ok;

  logic hsync_q, hsync_d;
  logic vsync_q, vsync_d;
  logic blank_q, blank_d;
  logic line_start_q, line_start_d;
  logic frame_start_q, frame_start_d;
  logic pix_req_q, pix_req_d;
  logic running_q, running_d;

  vga_lock_qualifier #(
    .LOCK_WAIT (LOCK_WAIT)
  ) u_lock_qualifier (
    .clk        (clk),
    .rst        (rst),
    .pll_locked (pll_locked),
    .run        (state_q == StRun),
    .lk_s       (lk_s),
    .lock_ok    (lock_ok)
  );

  // Next state and counters. Counters read zero whenever the next state is
  // WAIT_LOCK, so a lock drop aborts the frame on the same edge.
  always_comb begin
    state_d = state_q;
    h_d     = '0;
    v_d     = '0;
    case (state_q)
      StWaitLock: begin
        if (lock_ok) begin
          state_d = StRun;
        end
      end
      StRun: begin
        if (!lk_s) begin
          state_d = StWaitLock;
        end else if (h_q == HLast) begin
          h_d = '0;
          v_d = (v_q == VLast) ? '0 : v_q + COORD_W'(1);
        end else begin
          h_d = h_q + COORD_W'(1);
          v_d = v_q;
        end
      end
      default: state_d = StWaitLock;
    endcase
  end

  // Output decode of the next (h,v); idle values unless running next cycle.
  always_comb begin
    running_d     = (state_d == StRun);
    hsync_d       = ~HS_POL;
    vsync_d       = ~VS_POL;
    blank_d       = 1'b1;
    line_start_d  = 1'b0;
    frame_start_d = 1'b0;
    pix_req_d     = 1'b0;
    if (running_d) begin
      hsync_d       = (h_d >= HsFirst && h_d <= HsLast) ? HS_POL : ~HS_POL;
      vsync_d       = (v_d >= VsFirst && v_d <= VsLast) ? VS_POL : ~VS_POL;
      blank_d       = (h_d >= HAct) || (v_d >= VAct);
      line_start_d  = (h_d == '0);
      frame_start_d = (h_d == '0) && (v_d == '0);
      // Widened sum so the lead never wraps into the next line.
      pix_req_d     = (v_d < VAct) && (({1'b0, h_d} + LeadX) < HActX);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= StWaitLock;
      h_q           <= '0;
      v_q           <= '0;
      hsync_q       <= ~HS_POL;
      vsync_q       <= ~VS_POL;
      blank_q       <= 1'b1;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
      pix_req_q     <= 1'b0;
      running_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      h_q           <= h_d;
      v_q           <= v_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      blank_q       <= blank_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
      pix_req_q     <= pix_req_d;
      running_q     <= running_d;
    end
  end

  assign vga.hsync       = hsync_q;
  assign vga.vsync       = vsync_q;
  assign vga.blank       = blank_q;
  assign vga.pix_x       = h_q;
  assign vga.pix_y       = v_q;
  assign vga.line_start  = line_start_q;
  assign vga.frame_start = frame_start_q;
  assign vga.pix_req     = pix_req_q;
  assign vga.running     = running_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Self-checking bench for vga_timing_gen using a reduced raster geometry so
// whole frames fit in a short run. A cycle-count reference model derives the
// expected outputs from the time spent in RUN.
module tb_vga_timing_gen;

  localparam int HA = 40, HF = 4, HS = 6, HB = 5;
  localparam int VA = 20, VF = 2, VS = 2, VB = 3;
  localparam int LW = 16, PL = 2;
  localparam bit HP = 1'b0, VP = 1'b0;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int FT = HT * VT;
  localparam logic [26:0] IDLE = {1'b0, 1'b0, 1'b0, 1'b0, 1'b1, ~VP, ~HP, 10'd0, 10'd0};

  logic clk;
  logic rst;
  logic pll_locked;

  vga_timing_gen_if vga ();

  vga_timing_gen #(
    .H_ACTIVE  (HA),
    .H_FP      (HF),
    .H_SYNC    (HS),
    .H_BP      (HB),
    .V_ACTIVE  (VA),
    .V_FP      (VF),
    .V_SYNC    (VS),
    .V_BP      (VB),
    .HS_POL    (HP),
    .VS_POL    (VP),
    .LOCK_WAIT (LW),
    .PIX_LEAD  (PL)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .pll_locked (pll_locked),
    .vga        (vga)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // Reference model state: two-stage lock delay, locked streak, run time.
  bit m_s1 = 1'b0, m_s2 = 1'b0, m_run = 1'b0;
  int m_streak = 0;
  int m_t = 0;

  task automatic check_eq(string tag, logic [31:0] got, logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic void model_edge(bit r, bit l);
    bit lk;
    if (r) begin
      m_run = 1'b0; m_streak = 0; m_s1 = 1'b0; m_s2 = 1'b0;
      return;
    end
    lk   = m_s2;
    m_s2 = m_s1;
    m_s1 = l;
    if (m_run) begin
      if (!lk) begin
        m_run = 1'b0; m_streak = 0;
      end else begin
        m_t++;
      end
    end else if (lk) begin
      m_streak++;
      if (m_streak == LW) begin
        m_run = 1'b1; m_t = 0; m_streak = 0;
      end
    end else begin
      m_streak = 0;
    end
  endfunction

  function automatic logic [26:0] model_outs();
    int h, v;
    bit hs, vs, bl, rq, ls, fs;
    if (!m_run) return IDLE;
    h  = m_t % HT;
    v  = (m_t / HT) % VT;
    hs = (h >= HA + HF && h < HA + HF + HS) ? HP : ~HP;
    vs = (v >= VA + VF && v < VA + VF + VS) ? VP : ~VP;
    bl = (h >= HA) || (v >= VA);
    rq = (v < VA) && (h + PL < HA);
    ls = (h == 0);
    fs = (h == 0) && (v == 0);
    return {1'b1, fs, ls, rq, bl, vs, hs, 10'(h), 10'(v)};
  endfunction

  function automatic logic [26:0] dut_outs();
    return {vga.running, vga.frame_start, vga.line_start, vga.pix_req, vga.blank,
            vga.vsync, vga.hsync, vga.pix_x, vga.pix_y};
  endfunction

  // One clock edge: model sees the inputs the DUT sampled, then compare.
  task automatic step();
    logic r, l;
    r = rst;
    l = pll_locked;
    @(posedge clk);
    model_edge(r, l);
    cyc++;
    #1;
    check_eq("outs", dut_outs(), model_outs());
  endtask

  task automatic wait_frame_start(output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (!vga.frame_start && n < 4 * FT);
    check_eq("frame_start_seen", vga.frame_start, 1);
  endtask

  task automatic goto_pos(input int x, input int y);
    int n;
    n = 0;
    while (!(vga.running && vga.pix_x == 10'(x) && vga.pix_y == 10'(y)) && n < 2 * FT) begin
      step();
      n++;
    end
    check_eq("reach_pos", {vga.pix_x, vga.pix_y}, {10'(x), 10'(y)});
  endtask

  initial begin
    int n, fell, fs_last, ls_last, vs_cnt, hs_cnt, rq_cnt, lo_left;
    bit ever;

    rst = 1'b1;
    pll_locked = 1'b0;
    repeat (3) step();
    check_eq("reset_running", vga.running, 0);
    check_eq("reset_blank", vga.blank, 1);

    // Lock high from the first sampling edge after reset release.
    rst = 1'b0;
    pll_locked = 1'b1;
    wait_frame_start(n);
    check_eq("lock_latency", n - 1, LW + 1);
    check_eq("first_pos", {vga.pix_x, vga.pix_y}, 0);
    check_eq("first_blank", vga.blank, 0);
    check_eq("first_line_start", vga.line_start, 1);

    // Two full frames with period and width measurements.
    fs_last = 0; ls_last = 0; vs_cnt = 0; hs_cnt = 0;
    rq_cnt = vga.pix_req ? 1 : 0;
    for (int i = 1; i <= 2 * FT; i++) begin
      step();
      if (vga.frame_start) begin
        check_eq("frame_period", i - fs_last, FT);
        fs_last = i;
      end
      if (vga.line_start) begin
        check_eq("line_period", i - ls_last, HT);
        ls_last = i;
      end
      if (i < FT) begin
        if (vga.vsync == VP) vs_cnt++;
        if (vga.pix_req) rq_cnt++;
        if (i < HT && vga.hsync == HP) hs_cnt++;
      end
    end
    check_eq("frames_seen", fs_last, 2 * FT);
    check_eq("vsync_cycles", vs_cnt, VS * HT);
    check_eq("hsync_cycles", hs_cnt, HS);
    check_eq("pix_req_cycles", rq_cnt, VA * (HA - PL));

    // One-cycle lock drop mid-frame.
    goto_pos(10, 5);
    pll_locked = 1'b0;
    step();
    pll_locked = 1'b1;
    fell = -1;
    for (int i = 1; i <= 3; i++) begin
      step();
      if (fell < 0 && !vga.running) begin
        fell = i;
        check_eq("drop_idle", dut_outs(), IDLE);
      end
    end
    check_eq("drop_fell_within", (fell >= 1 && fell <= 2), 1);
    wait_frame_start(n);
    check_eq("relock_latency", n + 2, LW + 1);

    // Short lock glitches must never let the generator run.
    pll_locked = 1'b0;
    repeat (4) step();
    ever = 1'b0;
    repeat (20) begin
      pll_locked = 1'b1;
      repeat (10) begin
        step();
        ever |= vga.running;
      end
      pll_locked = 1'b0;
      step();
      ever |= vga.running;
    end
    check_eq("glitch_no_run", ever, 0);

    // Reset and lock rising together: reset wins, then normal qualification.
    rst = 1'b1;
    pll_locked = 1'b1;
    step();
    check_eq("rst_wins", vga.running, 0);
    rst = 1'b0;
    wait_frame_start(n);
    check_eq("rst_wins_latency", n - 1, LW + 1);

    // One-cycle reset mid-frame with lock stable.
    goto_pos(50, 15);
    rst = 1'b1;
    step();
    check_eq("rst_idle", dut_outs(), IDLE);
    rst = 1'b0;
    wait_frame_start(n);
    check_eq("rst_relock_latency", n - 1, LW + 1);

    // Random lock drops and resets, checked cycle by cycle against the model.
    lo_left = 0;
    for (int i = 0; i < 4000; i++) begin
      if (lo_left == 0 && $urandom_range(0, 299) == 0) lo_left = $urandom_range(1, 20);
      pll_locked = (lo_left == 0);
      if (lo_left > 0) lo_left--;
      rst = ($urandom_range(0, 1499) == 0);
      step();
    end
    rst = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
